execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- Execute stage of the 16-bit pipeline, directly downstream of the decode/execute buffer; consumes its registered outputs every cycle.
- Performs ALU operation, owns condition-code register (CCR), resolves branches, squashes wrong-path instructions after a taken branch.
- Registered results plus passthrough control go to the execute/memory buffer.

Parameters:
- WIDTH, 16, datapath width
- FLUSH_DEPTH, 2, number of following instructions squashed after a taken branch (1..3)

Ports:
- Clk  input  1  clock; all state on posedge
- Rst  input  1  synchronous active-high reset
- aluSignals  input  4  ALU op code
- Reg1  input  WIDTH  operand A / branch target
- Reg2  input  WIDTH  operand B / store data
- instr  input  WIDTH  immediate word
- ALU_src  input  1  1: B = instr, 0: B = Reg2
- SetC  input  1  force C=1
- CLRC  input  1  force C=0
- Branch  input  1  branch instruction
- Instruction  input  5  opcode; [1:0] selects branch condition
- RegDestination  input  3  write-back register
- RW, MR, MW, MTR  input  1 each  control passthrough
- ALUResult  output  WIDTH  registered ALU result
- StoreDataOut  output  WIDTH  registered Reg2
- RegDestinationOut  output  3  registered
- RWOut, MROut, MWOut, MTROut  output  1 each  registered, squash-gated
- CCR  output  3  {C,N,Z} flag register
- BranchTaken  output  1  registered one-cycle pulse
- BranchTarget  output  WIDTH  registered Reg1 of the taken branch
- FlushActive  output  1  high while flush counter nonzero

Behaviour:
- Reset (Rst=1 at posedge): all outputs 0, CCR=000, flush counter=0; overrides any in-flight branch/flush.
- Latency 1: inputs sampled at posedge N appear on outputs after posedge N; CCR updates at same edge.
- B = ALU_src ? instr : Reg2.
- aluSignals: 0000 result=A, no flags; 0001 ~A; 0010 A+1; 0011 A-1; 0100 A+B; 0101 A-B; 0110 A&B; 0111 A|B; 1000 A<<instr[3:0]; 1001 A>>instr[3:0] (logical); 1010 result=B, no flags; 1011-1111 result=0, no flags.
- Z=(result==0), N=result[WIDTH-1], updated for codes 0001-1001.
- C: ADD/INC = carry out of WIDTH bits; SUB/DEC = borrow (A<B, A==0 for DEC); shift = last bit shifted out, unchanged if shift amount 0; unchanged for NOT/AND/OR.
- SetC/CLRC applied after ALU carry; both high -> SetC wins.
- Branch: condition from CCR before this edge's update. Instruction[1:0]: 00 JZ(Z), 01 JN(N), 10 JC(C), 11 JMP(always). Taken -> BranchTaken=1 next cycle, BranchTarget=Reg1, tested flag cleared (JMP clears none), counter loaded with FLUSH_DEPTH. Not taken -> BranchTaken=0, flags unchanged.
- Branch instruction itself: RWOut, MWOut, MROut = 0.
- Squash: instruction sampled while counter nonzero is a NOP: RWOut=MWOut=MROut=MTROut=0, no CCR change, Branch ignored, SetC/CLRC ignored; counter decrements by 1 per cycle to 0. ALUResult still loads (don't-care downstream).
- FlushActive = (counter != 0), registered.
- BranchTaken high exactly one cycle per taken branch; a branch in the shadow never retriggers.

Test Plan:
- Rst high 1 cycle with nonzero inputs -> all outputs 0, CCR=000, FlushActive=0.
- ADD Reg1=FFFF, Reg2=0001, ALU_src=0 -> ALUResult=0000, CCR={C=1,N=0,Z=1} next cycle.
- SUB Reg1=0003, instr=0005, ALU_src=1 -> ALUResult=FFFE, CCR={1,1,0}; then SetC=CLRC=1 with op 0000 -> C=1, Z,N unchanged.
- CCR Z=1, Branch with Instruction[1:0]=00, Reg1=0040 -> BranchTaken pulse, BranchTarget=0040, Z cleared, FlushActive high 2 cycles; two following ADDs with RW=1 give RWOut=0 and CCR unchanged; third ADD writes normally.
- JN with N=0 -> BranchTaken=0, FlushActive=0, next instruction executes.
- Rst asserted during second flush cycle -> counter 0, FlushActive=0 next cycle; following instruction not squashed.

Source files
------------

// File: rtl/execute_stage.sv
// Execute stage of the 16-bit pipeline.
// Runs the ALU, owns the {C,N,Z} condition-code register, resolves branches
// against the flags as they stood before this cycle, and squashes the
// wrong-path instructions that follow a taken branch. All outputs are
// registered and feed the execute/memory buffer.

module execute_stage #(
  parameter int WIDTH       = 16,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [3:0]       aluSignals,
  input  logic [WIDTH-1:0] Reg1,
  input  logic [WIDTH-1:0] Reg2,
  input  logic [WIDTH-1:0] instr,
  input  logic             ALU_src,
  input  logic             SetC,
  input  logic             CLRC,
  input  logic             Branch,
  input  logic [4:0]       Instruction,
  input  logic [2:0]       RegDestination,
  input  logic             RW,
  input  logic             MR,
  input  logic             MW,
  input  logic             MTR,
  output logic [WIDTH-1:0] ALUResult,
  output logic [WIDTH-1:0] StoreDataOut,
  output logic [2:0]       RegDestinationOut,
  output logic             RWOut,
  output logic             MROut,
  output logic             MWOut,
  output logic             MTROut,
  output logic [2:0]       CCR,
  output logic             BranchTaken,
  output logic [WIDTH-1:0] BranchTarget,
  output logic             FlushActive
);

  typedef enum logic [3:0] {
    ALU_PASSA = 4'b0000,
    ALU_NOT   = 4'b0001,
    ALU_INC   = 4'b0010,
    ALU_DEC   = 4'b0011,
    ALU_ADD   = 4'b0100,
    ALU_SUB   = 4'b0101,
    ALU_AND   = 4'b0110,
    ALU_OR    = 4'b0111,
    ALU_SHL   = 4'b1000,
    ALU_SHR   = 4'b1001,
    ALU_PASSB = 4'b1010
  } aluOp_e;

  typedef enum logic [1:0] {
    BR_JZ  = 2'b00,
    BR_JN  = 2'b01,
    BR_JC  = 2'b10,
    BR_JMP = 2'b11
  } brCond_e;

  localparam int         CCR_C      = 2;
  localparam int         CCR_N      = 1;
  localparam int         CCR_Z      = 0;
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_DEPTH);

  // ALU datapath signals
  logic [WIDTH-1:0] operandB;
  logic [3:0]       shamt;
  logic [WIDTH:0]   wideSum;
  logic [WIDTH:0]   shlWide;
  logic [WIDTH:0]   shrWide;
  logic [WIDTH-1:0] aluRes;
  logic             aluCarry;
  logic             updZN;
  logic             updC;

  // Registered state and its next-state values
  logic [WIDTH-1:0] aluResult_q, aluResult_d;
  logic [WIDTH-1:0] storeData_q, storeData_d;
  logic [2:0]       regDest_q, regDest_d;
  logic             rw_q, rw_d;
  logic             mr_q, mr_d;
  logic             mw_q, mw_d;
  logic             mtr_q, mtr_d;
  logic [2:0]       ccr_q, ccr_d;
  logic             branchTaken_q, branchTaken_d;
  logic [WIDTH-1:0] branchTarget_q, branchTarget_d;
  logic [1:0]       flushCnt_q, flushCnt_d;
  logic             flushActive_q, flushActive_d;

  logic             squash;
  logic             condMet;
  logic             unusedInstrBits;

  assign unusedInstrBits = ^Instruction[4:2];

  // ALU: result plus which flags this op is allowed to touch
  always_comb begin
    operandB = ALU_src ? instr : Reg2;
    shamt    = instr[3:0];
    shlWide  = {1'b0, Reg1} << shamt;
    shrWide  = {Reg1, 1'b0} >> shamt;
    wideSum  = '0;
    aluRes   = '0;
    aluCarry = 1'b0;
    updZN    = 1'b0;
    updC     = 1'b0;
    case (aluOp_e'(aluSignals))
      ALU_PASSA: aluRes = Reg1;
      ALU_NOT: begin
        aluRes = ~Reg1;
        updZN  = 1'b1;
      end
      ALU_INC: begin
        wideSum  = {1'b0, Reg1} + (WIDTH+1)'(1);
        aluRes   = wideSum[WIDTH-1:0];
        aluCarry = wideSum[WIDTH];
        updZN    = 1'b1;
        updC     = 1'b1;
      end
      ALU_DEC: begin
        wideSum  = {1'b0, Reg1} - (WIDTH+1)'(1);
        aluRes   = wideSum[WIDTH-1:0];
        aluCarry = wideSum[WIDTH];
        updZN    = 1'b1;
        updC     = 1'b1;
      end
      ALU_ADD: begin
        wideSum  = {1'b0, Reg1} + {1'b0, operandB};
        aluRes   = wideSum[WIDTH-1:0];
        aluCarry = wideSum[WIDTH];
        updZN    = 1'b1;
        updC     = 1'b1;
      end
      ALU_SUB: begin
        wideSum  = {1'b0, Reg1} - {1'b0, operandB};
        aluRes   = wideSum[WIDTH-1:0];
        aluCarry = wideSum[WIDTH];
        updZN    = 1'b1;
        updC     = 1'b1;
      end
      ALU_AND: begin
        aluRes = Reg1 & operandB;
        updZN  = 1'b1;
      end
      ALU_OR: begin
        aluRes = Reg1 | operandB;
        updZN  = 1'b1;
      end
      ALU_SHL: begin
        aluRes   = shlWide[WIDTH-1:0];
        aluCarry = shlWide[WIDTH];
        updZN    = 1'b1;
        updC     = (shamt != 4'd0);
      end
      ALU_SHR: begin
        aluRes   = shrWide[WIDTH:1];
        aluCarry = shrWide[0];
        updZN    = 1'b1;
        updC     = (shamt != 4'd0);
      end
      ALU_PASSB: aluRes = operandB;
      default:   aluRes = '0;
    endcase
  end

  // Branch resolution, flag update, squash control and output staging
  always_comb begin
    squash         = (flushCnt_q != 2'd0);
    condMet        = 1'b0;
    aluResult_d    = aluRes;
    storeData_d    = Reg2;
    regDest_d      = RegDestination;
    rw_d           = 1'b0;
    mr_d           = 1'b0;
    mw_d           = 1'b0;
    mtr_d          = 1'b0;
    ccr_d          = ccr_q;
    branchTaken_d  = 1'b0;
    branchTarget_d = branchTarget_q;
    flushCnt_d     = flushCnt_q;

    if (squash) begin
      flushCnt_d = flushCnt_q - 2'd1;
    end else if (Branch) begin
      mtr_d = MTR;
      case (brCond_e'(Instruction[1:0]))
        BR_JZ:   condMet = ccr_q[CCR_Z];
        BR_JN:   condMet = ccr_q[CCR_N];
        BR_JC:   condMet = ccr_q[CCR_C];
        default: condMet = 1'b1;
      endcase
      if (condMet) begin
        branchTaken_d  = 1'b1;
        branchTarget_d = Reg1;
        flushCnt_d     = FLUSH_LOAD;
        case (brCond_e'(Instruction[1:0]))
          BR_JZ:   ccr_d[CCR_Z] = 1'b0;
          BR_JN:   ccr_d[CCR_N] = 1'b0;
          BR_JC:   ccr_d[CCR_C] = 1'b0;
          default: ccr_d = ccr_q;
        endcase
      end
    end else begin
      rw_d  = RW;
      mr_d  = MR;
      mw_d  = MW;
      mtr_d = MTR;
      if (updZN) begin
        ccr_d[CCR_Z] = (aluRes == '0);
        ccr_d[CCR_N] = aluRes[WIDTH-1];
      end
      if (updC) begin
        ccr_d[CCR_C] = aluCarry;
      end
      if (SetC) begin
        ccr_d[CCR_C] = 1'b1;
      end else if (CLRC) begin
        ccr_d[CCR_C] = 1'b0;
      end
    end

    flushActive_d = (flushCnt_d != 2'd0);
  end

  // Pipeline registers, CCR and flush counter
  always_ff @(posedge Clk) begin
    if (Rst) begin
      aluResult_q    <= '0;
      storeData_q    <= '0;
      regDest_q      <= '0;
      rw_q           <= 1'b0;
      mr_q           <= 1'b0;
      mw_q           <= 1'b0;
      mtr_q          <= 1'b0;
      ccr_q          <= '0;
      branchTaken_q  <= 1'b0;
      branchTarget_q <= '0;
      flushCnt_q     <= '0;
      flushActive_q  <= 1'b0;
    end else begin
      aluResult_q    <= aluResult_d;
      storeData_q    <= storeData_d;
      regDest_q      <= regDest_d;
      rw_q           <= rw_d;
      mr_q           <= mr_d;
      mw_q           <= mw_d;
      mtr_q          <= mtr_d;
      ccr_q          <= ccr_d;
      branchTaken_q  <= branchTaken_d;
      branchTarget_q <= branchTarget_d;
      flushCnt_q     <= flushCnt_d;
      flushActive_q  <= flushActive_d;
    end
  end

  assign ALUResult         = aluResult_q;
  assign StoreDataOut      = storeData_q;
  assign RegDestinationOut = regDest_q;
  assign RWOut             = rw_q;
  assign MROut             = mr_q;
  assign MWOut             = mw_q;
  assign MTROut            = mtr_q;
  assign CCR               = ccr_q;
  assign BranchTaken       = branchTaken_q;
  assign BranchTarget      = branchTarget_q;
  assign FlushActive       = flushActive_q;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios followed by
// randomized instruction streams, all compared against an arithmetic model.

module tb_execute_stage;

  localparam int WIDTH       = 16;
  localparam int FLUSH_DEPTH = 2;

  logic             Clk;
  logic             Rst;
  logic [3:0]       aluSignals;
  logic [WIDTH-1:0] Reg1;
  logic [WIDTH-1:0] Reg2;
  logic [WIDTH-1:0] instr;
  logic             ALU_src;
  logic             SetC;
  logic             CLRC;
  logic             Branch;
  logic [4:0]       Instruction;
  logic [2:0]       RegDestination;
  logic             RW;
  logic             MR;
  logic             MW;
  logic             MTR;
  logic [WIDTH-1:0] ALUResult;
  logic [WIDTH-1:0] StoreDataOut;
  logic [2:0]       RegDestinationOut;
  logic             RWOut;
  logic             MROut;
  logic             MWOut;
  logic             MTROut;
  logic [2:0]       CCR;
  logic             BranchTaken;
  logic [WIDTH-1:0] BranchTarget;
  logic             FlushActive;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit mC, mN, mZ;
  int mFlush;
  int expAlu, expStore, expDest, expCtrl, expBT, expTarget, expFlushActive;

  execute_stage #(.WIDTH(WIDTH), .FLUSH_DEPTH(FLUSH_DEPTH)) dut (
    .Clk(Clk), .Rst(Rst), .aluSignals(aluSignals), .Reg1(Reg1), .Reg2(Reg2),
    .instr(instr), .ALU_src(ALU_src), .SetC(SetC), .CLRC(CLRC), .Branch(Branch),
    .Instruction(Instruction), .RegDestination(RegDestination),
    .RW(RW), .MR(MR), .MW(MW), .MTR(MTR),
    .ALUResult(ALUResult), .StoreDataOut(StoreDataOut),
    .RegDestinationOut(RegDestinationOut),
    .RWOut(RWOut), .MROut(MROut), .MWOut(MWOut), .MTROut(MTROut),
    .CCR(CCR), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .FlushActive(FlushActive)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Behavioural model of one clock edge, working on plain integers
  task automatic modelStep();
    int a, b, s, res, carry;
    bit updZN, updC, taken;
    if (Rst) begin
      mC = 0; mN = 0; mZ = 0; mFlush = 0;
      expAlu = 0; expStore = 0; expDest = 0; expCtrl = 0;
      expBT = 0; expTarget = 0; expFlushActive = 0;
      return;
    end
    a = int'(Reg1);
    b = ALU_src ? int'(instr) : int'(Reg2);
    s = int'(instr[3:0]);
    res = 0; carry = 0; updZN = 0; updC = 0;
    case (int'(aluSignals))
      0:  res = a;
      1:  begin res = 65535 - a; updZN = 1; end
      2:  begin res = (a + 1) % 65536; carry = (a + 1 > 65535); updZN = 1; updC = 1; end
      3:  begin res = (a + 65535) % 65536; carry = (a == 0); updZN = 1; updC = 1; end
      4:  begin res = (a + b) % 65536; carry = (a + b > 65535); updZN = 1; updC = 1; end
      5:  begin res = (a - b + 65536) % 65536; carry = (a < b); updZN = 1; updC = 1; end
      6:  begin res = a & b; updZN = 1; end
      7:  begin res = a | b; updZN = 1; end
      8:  begin
            res = (a << s) % 65536; updZN = 1;
            if (s > 0) begin carry = (a >> (16 - s)) % 2; updC = 1; end
          end
      9:  begin
            res = a >> s; updZN = 1;
            if (s > 0) begin carry = (a >> (s - 1)) % 2; updC = 1; end
          end
      10: res = b;
      default: res = 0;
    endcase
    expAlu   = res;
    expStore = int'(Reg2);
    expDest  = int'(RegDestination);
    expBT    = 0;
    if (mFlush > 0) begin
      mFlush  = mFlush - 1;
      expCtrl = 0;
    end else if (Branch) begin
      expCtrl = int'(MTR);
      case (int'(Instruction[1:0]))
        0:       taken = mZ;
        1:       taken = mN;
        2:       taken = mC;
        default: taken = 1;
      endcase
      if (taken) begin
        expBT     = 1;
        expTarget = int'(Reg1);
        mFlush    = FLUSH_DEPTH;
        if (Instruction[1:0] == 2'd0) mZ = 0;
        if (Instruction[1:0] == 2'd1) mN = 0;
        if (Instruction[1:0] == 2'd2) mC = 0;
      end
    end else begin
      expCtrl = {28'd0, RW, MR, MW, MTR};
      if (updZN) begin
        mZ = (res == 0);
        mN = (res >= 32768);
      end
      if (updC) mC = carry[0];
      if (SetC) mC = 1;
      else if (CLRC) mC = 0;
    end
    expFlushActive = (mFlush > 0);
  endtask

  // Advance one edge, update the model, then compare every output
  task automatic runCycle();
    @(posedge Clk);
    modelStep();
    #1;
    checkOutput("ALUResult", 32'(ALUResult), expAlu);
    checkOutput("StoreDataOut", 32'(StoreDataOut), expStore);
    checkOutput("RegDestOut", 32'(RegDestinationOut), expDest);
    checkOutput("ctrlOut", {28'd0, RWOut, MROut, MWOut, MTROut}, expCtrl);
    checkOutput("CCR", 32'(CCR), {29'd0, mC, mN, mZ});
    checkOutput("BranchTaken", 32'(BranchTaken), expBT);
    checkOutput("BranchTarget", 32'(BranchTarget), expTarget);
    checkOutput("FlushActive", 32'(FlushActive), expFlushActive);
    @(negedge Clk);
  endtask

  // Drive one instruction on the falling edge and run it through a cycle
  task automatic applyStimulus(input logic rst, input logic [3:0] op,
                               input logic [15:0] r1, input logic [15:0] r2,
                               input logic [15:0] imm, input logic src,
                               input logic setc, input logic clrc,
                               input logic br, input logic [4:0] ins,
                               input logic [2:0] dest, input logic [3:0] ctrl);
    Rst = rst; aluSignals = op; Reg1 = r1; Reg2 = r2; instr = imm;
    ALU_src = src; SetC = setc; CLRC = clrc; Branch = br; Instruction = ins;
    RegDestination = dest;
    {RW, MR, MW, MTR} = ctrl;
    runCycle();
  endtask

  function automatic logic [15:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    Rst = 1'b0; aluSignals = '0; Reg1 = '0; Reg2 = '0; instr = '0;
    ALU_src = 1'b0; SetC = 1'b0; CLRC = 1'b0; Branch = 1'b0; Instruction = '0;
    RegDestination = '0; RW = 1'b0; MR = 1'b0; MW = 1'b0; MTR = 1'b0;
    mC = 0; mN = 0; mZ = 0; mFlush = 0;
    @(negedge Clk);

    // Reset with busy inputs, including a jump that must not take effect
    applyStimulus(1, 4'h4, 16'h1234, 16'h5678, 16'h9ABC, 1, 1, 0, 1, 5'h03, 3'd5, 4'hF);
    // ADD FFFF + 0001 -> 0, C=1 Z=1
    applyStimulus(0, 4'h4, 16'hFFFF, 16'h0001, 16'h0000, 0, 0, 0, 0, 5'h00, 3'd1, 4'h8);
    // SUB 3 - imm 5 -> FFFE, C=1 N=1
    applyStimulus(0, 4'h5, 16'h0003, 16'h0000, 16'h0005, 1, 0, 0, 0, 5'h00, 3'd2, 4'h8);
    // CLRC alone, then SetC and CLRC together
    applyStimulus(0, 4'h0, 16'h0007, 16'h0000, 16'h0000, 0, 0, 1, 0, 5'h00, 3'd3, 4'h0);
    applyStimulus(0, 4'h0, 16'h0007, 16'h0000, 16'h0000, 0, 1, 1, 0, 5'h00, 3'd3, 4'h0);
    // Set Z, then JZ to 0040 and two shadow ADDs followed by a real one
    applyStimulus(0, 4'h4, 16'hFFFF, 16'h0001, 16'h0000, 0, 0, 0, 0, 5'h00, 3'd1, 4'h8);
    applyStimulus(0, 4'h0, 16'h0040, 16'h0011, 16'h0000, 0, 0, 0, 1, 5'h00, 3'd0, 4'hF);
    applyStimulus(0, 4'h4, 16'h0001, 16'h0001, 16'h0000, 0, 1, 0, 1, 5'h03, 3'd4, 4'h8);
    applyStimulus(0, 4'h4, 16'h0002, 16'h0002, 16'h0000, 0, 0, 0, 0, 5'h00, 3'd5, 4'h8);
    applyStimulus(0, 4'h4, 16'h0003, 16'h0003, 16'h0000, 0, 0, 0, 0, 5'h00, 3'd6, 4'h8);
    // JN with N=0 is not taken and the next instruction executes
    applyStimulus(0, 4'h0, 16'h0080, 16'h0000, 16'h0000, 0, 0, 0, 1, 5'h01, 3'd0, 4'h0);
    applyStimulus(0, 4'h3, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 5'h00, 3'd7, 4'hC);
    // Shifts at the edges of the shift amount
    applyStimulus(0, 4'h8, 16'h8001, 16'h0000, 16'h0001, 0, 0, 0, 0, 5'h00, 3'd1, 4'h8);
    applyStimulus(0, 4'h9, 16'h0003, 16'h0000, 16'h0000, 0, 0, 0, 0, 5'h00, 3'd1, 4'h8);
    applyStimulus(0, 4'h9, 16'hC000, 16'h0000, 16'h000F, 0, 0, 0, 0, 5'h00, 3'd1, 4'h8);
    // JMP, then reset during the second flush cycle
    applyStimulus(0, 4'h0, 16'h0100, 16'h0000, 16'h0000, 0, 0, 0, 1, 5'h03, 3'd0, 4'h0);
    applyStimulus(0, 4'h4, 16'h0001, 16'h0001, 16'h0000, 0, 0, 0, 0, 5'h00, 3'd2, 4'h8);
    applyStimulus(1, 4'h4, 16'h0001, 16'h0001, 16'h0000, 0, 0, 0, 0, 5'h00, 3'd2, 4'h8);
    applyStimulus(0, 4'h4, 16'h0005, 16'h0006, 16'h0000, 0, 0, 0, 0, 5'h00, 3'd3, 4'hA);

    // Randomized instruction stream with frequent branches and rare resets
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 49) == 0),
                    4'($urandom_range(0, 15)),
                    pickOperand(), pickOperand(),
                    ($urandom_range(0, 1) == 1) ? pickOperand() : 16'($urandom_range(0, 15)),
                    1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 4) == 0), 5'($urandom), 3'($urandom), 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
